// File: rtl/instr_fetch_decode.sv
// Instruction fetch/decode for an 8-bit IMEM: owns the PC, resolves jump/halt locally and
// hands add/load/store to the datapath through a valid/ready handshake.
module instr_fetch_decode #(
  parameter int         PROG_DEPTH = 32,
  parameter logic [5:0] HALT_IMM   = 6'b000011
) (
  input  logic       clk,
  input  logic       clear_n,
  input  logic       start,
  output logic [7:0] address,
  input  logic [7:0] instruction,
  output logic       issue_valid,
  input  logic       issue_ready,
  output logic [1:0] op,
  output logic [1:0] rs,
  output logic [1:0] rt,
  output logic [1:0] rd,
  output logic [7:0] imm,
  output logic       halted,
  output logic [7:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_ISSUE  = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [8:0] PROG_DEPTH9 = 9'(PROG_DEPTH);

  state_t     r_state;
  logic [7:0] r_pc;
  logic [7:0] r_ir;
  logic [7:0] r_retired;
  logic       r_issue_valid;
  logic       r_halted;
  logic [1:0] r_op;
  logic [1:0] r_rs;
  logic [1:0] r_rt;
  logic [1:0] r_rd;
  logic [7:0] r_imm;

  logic       w_is_jump;
  logic       w_is_halt;
  logic [7:0] w_jump_sum;
  logic [7:0] w_jump_pc;
  logic [7:0] w_next_pc;

  // 8-bit PC arithmetic folded back into the program range; 9-bit divisor allows depth 256
  function automatic logic [7:0] wrap_pc(input logic [7:0] v);
    logic [8:0] t;
    t = {1'b0, v} % PROG_DEPTH9;
    return t[7:0];
  endfunction

  assign w_is_jump  = (r_ir[7:6] == 2'b11);
  assign w_is_halt  = w_is_jump && (r_ir[5:0] == HALT_IMM);
  assign w_jump_sum = r_pc + 8'd1 + {{2{r_ir[5]}}, r_ir[5:0]};
  assign w_jump_pc  = wrap_pc(w_jump_sum);
  assign w_next_pc  = wrap_pc(r_pc + 8'd1);

  // Sequencer: one state register plus every output register
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_state       <= S_IDLE;
      r_pc          <= 8'd0;
      r_ir          <= 8'd0;
      r_retired     <= 8'd0;
      r_issue_valid <= 1'b0;
      r_halted      <= 1'b0;
      r_op          <= 2'd0;
      r_rs          <= 2'd0;
      r_rt          <= 2'd0;
      r_rd          <= 2'd0;
      r_imm         <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_pc    <= 8'd0;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          r_ir    <= instruction;
          r_state <= S_DECODE;
        end
        S_DECODE: begin
          if (w_is_halt) begin
            r_halted <= 1'b1;
            r_state  <= S_HALT;
          end else if (w_is_jump) begin
            r_pc      <= w_jump_pc;
            r_retired <= r_retired + 8'd1;
            r_state   <= S_FETCH;
          end else begin
            r_op          <= r_ir[7:6];
            r_rs          <= r_ir[5:4];
            r_rt          <= r_ir[3:2];
            r_rd          <= r_ir[1:0];
            r_imm         <= {{6{r_ir[1]}}, r_ir[1:0]};
            r_issue_valid <= 1'b1;
            r_state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // fields stay frozen until the datapath takes them; no retraction
          if (issue_ready) begin
            r_issue_valid <= 1'b0;
            r_pc          <= w_next_pc;
            r_retired     <= r_retired + 8'd1;
            r_state       <= S_FETCH;
          end
        end
        S_HALT: begin
          if (start) begin
            r_halted <= 1'b0;
            r_pc     <= 8'd0;
            r_state  <= S_FETCH;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign address     = r_pc;
  assign issue_valid = r_issue_valid;
  assign op          = r_op;
  assign rs          = r_rs;
  assign rt          = r_rt;
  assign rd          = r_rd;
  assign imm         = r_imm;
  assign halted      = r_halted;
  assign retired     = r_retired;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Self-checking bench for instr_fetch_decode: directed scenarios plus a random program
// stream checked against an instruction-level interpreter of the IMEM contents.
module tb_instr_fetch_decode;

  logic       clk = 1'b0;
  logic       clear_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] address;
  logic [7:0] instruction;
  logic       issue_valid;
  logic       issue_ready = 1'b0;
  logic [1:0] op, rs, rt, rd;
  logic [7:0] imm;
  logic       halted;
  logic [7:0] retired;

  logic [7:0] imem [32];
  int checks = 0;
  int errors = 0;

  assign instruction = imem[address[4:0]];

  always #5 clk = ~clk;

  instr_fetch_decode #(.PROG_DEPTH(32), .HALT_IMM(6'b000011)) dut (
    .clk(clk), .clear_n(clear_n), .start(start), .address(address),
    .instruction(instruction), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .op(op), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .halted(halted), .retired(retired)
  );

  task automatic clear_imem();
    for (int i = 0; i < 32; i++) imem[i] = 8'h00;
  endtask

  task automatic do_reset();
    clear_n = 1'b0; start = 1'b0; issue_ready = 1'b0;
    repeat (2) @(negedge clk);
    clear_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    for (int i = 0; i < budget; i++) begin
      if (issue_valid) break;
      @(negedge clk);
    end
    ok = issue_valid;
  endtask

  // expected {op,rs,rt,rd,imm} straight from the instruction encoding
  function automatic logic [15:0] expect_fields(input logic [7:0] ins);
    int v;
    v = (ins[1:0] >= 2'd2) ? int'(ins[1:0]) - 4 : int'(ins[1:0]);
    return {ins[7:6], ins[5:4], ins[3:2], ins[1:0], 8'(v)};
  endfunction

  task automatic test_reset();
    clear_imem();
    clear_n = 1'b0; start = 1'b0; issue_ready = 1'b1;
    #1;
    checks++;
    if ({address, issue_valid, halted, retired, op, rs, rt, rd, imm} !== 34'd0) begin
      errors++;
      $display("FAIL reset_outputs: got addr=%0h v=%0b h=%0b ret=%0h imm=%0h, expected all zero",
               address, issue_valid, halted, retired, imm);
    end
    @(negedge clk); clear_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (issue_valid !== 1'b0 || address !== 8'd0 || retired !== 8'd0) begin
      errors++;
      $display("FAIL idle_hold: got v=%0b addr=%0h ret=%0h, expected 0/0/0", issue_valid, address, retired);
    end
    issue_ready = 1'b0;
  endtask

  task automatic test_first_issue();
    clear_imem();
    imem[0] = 8'b01001001;
    do_reset();
    pulse_start();
    checks++;
    if (issue_valid !== 1'b0 || address !== 8'd0) begin
      errors++;
      $display("FAIL fetch_cycle: got v=%0b addr=%0h, expected 0/0", issue_valid, address);
    end
    @(negedge clk);
    checks++;
    if (issue_valid !== 1'b0) begin
      errors++;
      $display("FAIL decode_cycle: got v=%0b, expected 0", issue_valid);
    end
    @(negedge clk);
    checks++;
    if (issue_valid !== 1'b1 || {op, rs, rt, imm} !== {2'b01, 2'd0, 2'd2, 8'h01}) begin
      errors++;
      $display("FAIL first_issue: got v=%0b op=%0h rs=%0h rt=%0h imm=%0h, expected 1 1 0 2 01",
               issue_valid, op, rs, rt, imm);
    end
    issue_ready = 1'b1;
    @(negedge clk);
    issue_ready = 1'b0;
    checks++;
    if (issue_valid !== 1'b0 || address !== 8'd1 || retired !== 8'd1) begin
      errors++;
      $display("FAIL first_accept: got v=%0b addr=%0h ret=%0h, expected 0 1 1", issue_valid, address, retired);
    end
  endtask

  task automatic test_jump_wrap();
    bit ok;
    clear_imem();
    imem[0] = 8'b11000100;   // 0 -> 5
    imem[5] = 8'b11111110;   // 5 -> 4
    imem[4] = 8'b00000111;
    do_reset();
    pulse_start();
    wait_valid(20, ok);
    checks++;
    if (!ok || address !== 8'd4 || retired !== 8'd2 ||
        {op, rs, rt, rd, imm} !== {2'b00, 2'd0, 2'd1, 2'd3, 8'hFF}) begin
      errors++;
      $display("FAIL jump_back: got ok=%0b addr=%0h ret=%0h op=%0h rs=%0h rt=%0h rd=%0h imm=%0h, expected 1 4 2 0 0 1 3 ff",
               ok, address, retired, op, rs, rt, rd, imm);
    end
    clear_imem();
    imem[0]  = 8'b11011110;  // 0 -> 31
    imem[31] = 8'b00011011;
    do_reset();
    pulse_start();
    wait_valid(20, ok);
    checks++;
    if (!ok || address !== 8'd31) begin
      errors++;
      $display("FAIL jump_to_31: got ok=%0b addr=%0h, expected 1 1f", ok, address);
    end
    issue_ready = 1'b1;
    @(negedge clk);
    issue_ready = 1'b0;
    checks++;
    if (address !== 8'd0 || issue_valid !== 1'b0 || retired !== 8'd2) begin
      errors++;
      $display("FAIL pc_wrap: got addr=%0h v=%0b ret=%0h, expected 0 0 2", address, issue_valid, retired);
    end
  endtask

  task automatic test_halt();
    bit seen;
    clear_imem();
    imem[0]  = 8'b11001001;  // 0 -> 10
    imem[10] = 8'b11000011;
    do_reset();
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (halted) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!seen || address !== 8'd10 || issue_valid !== 1'b0 || retired !== 8'd1) begin
      errors++;
      $display("FAIL halt_enter: got h=%0b addr=%0h v=%0b ret=%0h, expected 1 a 0 1", seen, address, issue_valid, retired);
    end
    issue_ready = 1'b1;
    repeat (4) @(negedge clk);
    issue_ready = 1'b0;
    checks++;
    if (halted !== 1'b1 || address !== 8'd10 || retired !== 8'd1 || issue_valid !== 1'b0) begin
      errors++;
      $display("FAIL halt_hold: got h=%0b addr=%0h ret=%0h v=%0b, expected 1 a 1 0", halted, address, retired, issue_valid);
    end
    pulse_start();
    checks++;
    if (halted !== 1'b0 || address !== 8'd0) begin
      errors++;
      $display("FAIL halt_restart: got h=%0b addr=%0h, expected 0 0", halted, address);
    end
  endtask

  task automatic test_reset_mid_issue();
    bit ok;
    clear_imem();
    imem[0] = 8'b11000001;   // 0 -> 2
    imem[2] = 8'b10100010;
    do_reset();
    pulse_start();
    wait_valid(20, ok);
    checks++;
    if (!ok || retired !== 8'd1 || {op, rs, rt, imm} !== {2'b10, 2'd2, 2'd0, 8'hFE}) begin
      errors++;
      $display("FAIL store_issue: got ok=%0b ret=%0h op=%0h rs=%0h rt=%0h imm=%0h, expected 1 1 2 2 0 fe",
               ok, retired, op, rs, rt, imm);
    end
    #2 clear_n = 1'b0;
    #1;
    checks++;
    if (issue_valid !== 1'b0 || address !== 8'd0 || retired !== 8'd0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL async_clear: got v=%0b addr=%0h ret=%0h h=%0b, expected all 0", issue_valid, address, retired, halted);
    end
    @(negedge clk);
    clear_n = 1'b1;
    issue_ready = 1'b1;
    repeat (4) @(negedge clk);
    issue_ready = 1'b0;
    checks++;
    if (issue_valid !== 1'b0 || address !== 8'd0 || retired !== 8'd0) begin
      errors++;
      $display("FAIL idle_after_clear: got v=%0b addr=%0h ret=%0h, expected 0 0 0", issue_valid, address, retired);
    end
  endtask

  // Random programs interpreted at instruction level; ready toggles randomly in every state
  task automatic test_random_stream(input int n_target);
    int m_pc, m_ret, n_issued, cycles, off, hops;
    bit in_issue;
    logic [7:0] cur;
    for (int i = 0; i < 32; i++) begin
      if (i < 4 || $urandom_range(3) != 0)
        imem[i] = {2'($urandom_range(2)), 6'($urandom)};
      else
        imem[i] = {2'b11, 4'b0000, 2'($urandom_range(2))};  // forward hop of 1..3
    end
    do_reset();
    pulse_start();
    m_pc = 0; m_ret = 0; n_issued = 0; cycles = 0; in_issue = 1'b0; cur = 8'h00;
    while (n_issued < n_target && cycles < 3000) begin
      @(negedge clk);
      cycles++;
      issue_ready = 1'($urandom_range(1));
      if (issue_valid) begin
        if (!in_issue) begin
          hops = 0;
          while (imem[m_pc][7:6] == 2'b11 && hops < 64) begin
            off = int'(imem[m_pc][5:0]);
            if (off >= 32) off -= 64;
            m_pc = (((m_pc + 1 + off) % 32) + 32) % 32;
            m_ret++;
            hops++;
          end
          cur = imem[m_pc];
          in_issue = 1'b1;
        end
        checks++;
        if ({op, rs, rt, rd, imm} !== expect_fields(cur)) begin
          errors++;
          $display("FAIL rand_fields: got %h expected %h at pc %0d", {op, rs, rt, rd, imm}, expect_fields(cur), m_pc);
        end
        checks++;
        if (address !== 8'(m_pc) || retired !== 8'(m_ret)) begin
          errors++;
          $display("FAIL rand_pc_ret: got addr=%0h ret=%0h expected %0h %0h", address, retired, 8'(m_pc), 8'(m_ret));
        end
        if (issue_ready) begin
          m_pc = (m_pc + 1) % 32;
          m_ret++;
          n_issued++;
          in_issue = 1'b0;
        end
      end
    end
    issue_ready = 1'b0;
    checks++;
    if (n_issued != n_target) begin
      errors++;
      $display("FAIL rand_progress: got %0d issues expected %0d", n_issued, n_target);
    end
  endtask

  initial begin
    test_reset();
    test_first_issue();
    test_jump_wrap();
    test_halt();
    test_reset_mid_issue();
    test_random_stream(60);
    test_random_stream(60);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
